// File: rtl/fsm_burst_source_if.sv
// Valid/ready source bus carrying 32-bit data words.
// Ports: valid (source), ready (sink), data (source); master = source side.
interface fsm_burst_source_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/fsm_burst_source.sv
// Burst transmitter FSM: emits len incrementing 32-bit words on a valid/ready bus.
// Ports: clk, rst (sync, active-high), start/burst_len/base_data/skip_wait request,
// pause/abort/clear_err control, src (master bus), state/counter/busy/done/error_flag status.
module fsm_burst_source #(
    parameter int WAIT_CYCLES = 4,
    parameter int PROC_CYCLES = 3,
    parameter int STALL_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             burst_len,
    input  logic [31:0]            base_data,
    input  logic                   skip_wait,
    input  logic                   pause,
    input  logic                   abort,
    input  logic                   clear_err,
    fsm_burst_source_if.master     src,
    output logic [2:0]             state,
    output logic [7:0]             counter,
    output logic                   busy,
    output logic                   done,
    output logic                   error_flag
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_WAIT   = 3'b001,
        S_ACTIVE = 3'b010,
        S_PROC   = 3'b011,
        S_DONE   = 3'b100,
        S_ERROR  = 3'b101
    } state_e;

    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [7:0]    WAIT_LAST  = 8'(WAIT_CYCLES - 1);
    localparam logic [7:0]    PROC_LAST  = 8'(PROC_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    state_e        state_q, state_d;
    logic [7:0]    counter_q, counter_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]    len_q, len_d;
    logic [31:0]   base_q, base_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          hs;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        base_d      = base_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        hs          = valid_q && src.ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = burst_len;
                    base_d      = base_data;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    if (burst_len == 8'd0)
                        state_d = S_ERROR;
                    else if (skip_wait)
                        state_d = S_ACTIVE;
                    else
                        state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort)
                    state_d = S_ERROR;
                else if (counter_q == WAIT_LAST)
                    state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                // Counters update regardless of abort; they are unused after it.
                if (hs) begin
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    stall_cnt_d = '0;
                end else if (valid_q) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                if (abort)
                    state_d = S_ERROR;
                else if (hs) begin
                    if (beat_cnt_q == len_q - 8'd1)
                        state_d = S_PROC;
                    else if (pause)
                        state_d = S_WAIT;
                end else if (STALL_LIMIT != 0 && stall_cnt_q == STALL_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_PROC: begin
                if (abort)
                    state_d = S_ERROR;
                else if (counter_q == PROC_LAST)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (clear_err)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        counter_d = (state_d != state_q) ? 8'd0 : counter_q + 8'd1;
        valid_d   = (state_d == S_ACTIVE);
        // Data only moves when a new beat is presented, keeping it stable under stall.
        data_d    = valid_d ? base_d + {24'd0, beat_cnt_d} : data_q;
        busy_d    = (state_d == S_WAIT) || (state_d == S_ACTIVE)
                 || (state_d == S_PROC);
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            counter_q   <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            len_q       <= '0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign src.valid  = valid_q;
    assign src.data   = data_q;
    assign state      = state_q;
    assign counter    = counter_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error_flag = error_q;

endmodule
